sub_one_14b: RTL and testbench

- 14-bit decrement-by-one unit for the stack-machine datapath. It is used for stack-pointer and counter decrement.
- Combinational output s = a - 1 (mod 2^14), plus a borrow flag.
- A registered copy of the result and flags is captured on the clock for pipelined consumers.
- Pure two's-complement/unsigned wrap arithmetic; no saturation.

---
 rtl/sub_one_14b.sv | 86 ++++++++
 tb/tb_sub_one_14b.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sub_one_14b.sv
// -----------------------------------------------------------------------------
// sub_one_14b
//   Decrement-by-one unit for the stack-machine datapath, used for
//   stack-pointer and counter decrement. Produces a - 1 (mod 2^WIDTH)
//   combinationally, together with a borrow flag (a was zero, so the result
//   wrapped) and a zero flag (the result is zero). A registered copy of all
//   three is kept for pipelined consumers.
//
// Ports
//   clk      : rising-edge clock for the registered outputs
//   rst_n    : synchronous, active-low reset of the registered outputs
//   a        : operand
//   en       : capture enable for the registered outputs
//   s        : combinational a - 1, wrapping modulo 2^WIDTH
//   borrow   : combinational, 1 when a == 0
//   zero     : combinational, 1 when s == 0 (a == 1)
//   s_q      : registered s
//   borrow_q : registered borrow
//   zero_q   : registered zero
// -----------------------------------------------------------------------------
module sub_one_14b #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             en,
    output logic [WIDTH-1:0] s,
    output logic             borrow,
    output logic             zero,
    output logic [WIDTH-1:0] s_q,
    output logic             borrow_q,
    output logic             zero_q
);

    // Borrow chain: b_chain[i] is the borrow into bit i. Injecting a borrow
    // into bit 0 subtracts one. The borrow ripples upward through the
    // trailing zeros of a and stops at the lowest set bit, so that bit is
    // cleared, the bits below it are set, and the bits above are unchanged.
    logic [WIDTH:0] b_chain;

    assign b_chain[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_borrow_chain
        assign s[i]           = a[i] ^ b_chain[i];
        assign b_chain[i + 1] = ~a[i] & b_chain[i];
    end

    // A borrow out of the top bit only happens when every bit of a is zero.
    assign borrow = b_chain[WIDTH];
    assign zero   = ~|s;

    // Next-state for the registered copy: capture when enabled, else hold.
    logic [WIDTH-1:0] s_d;
    logic             borrow_d;
    logic             zero_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        s_d      = s_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        if (en) begin
            s_d      = s;
            borrow_d = borrow;
            zero_d   = zero;
        end
    end

    // Reset is sampled on the clock edge and takes priority over en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state, so every register
            // samples the values from before the edge regardless of order.
            s_q      <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            s_q      <= s_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_sub_one_14b.sv
// -----------------------------------------------------------------------------
// tb_sub_one_14b
//   Self-checking bench for sub_one_14b: a table of combinational vectors,
//   hand-written reset/capture/hold/mid-stream-reset sequences, and a
//   randomised run. Expected registered values are pushed to a queue when
//   stimulus is driven and popped after the clock edge that produces them.
// -----------------------------------------------------------------------------
module tb_sub_one_14b;

    localparam int W = 14;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] s;
        logic         borrow;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         borrow;
        logic         zero;
    } reg_exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic         en;
    logic [W-1:0] s;
    logic         borrow;
    logic         zero;
    logic [W-1:0] s_q;
    logic         borrow_q;
    logic         zero_q;

    int checks   = 0;
    int failures = 0;

    reg_exp_t sb_q[$];
    reg_exp_t held;     // model of the registered outputs

    sub_one_14b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .en       (en),
        .s        (s),
        .borrow   (borrow),
        .zero     (zero),
        .s_q      (s_q),
        .borrow_q (borrow_q),
        .zero_q   (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic, written independently of the ripple structure.
    function automatic reg_exp_t model(input logic [W-1:0] av);
        reg_exp_t r;
        r.s      = W'(av - 1'b1);
        r.borrow = (av == '0);
        r.zero   = (av == W'(1));
        return r;
    endfunction

    task automatic check_comb(input string tag);
        reg_exp_t m;
        m = model(a);
        check({tag, ".s"},      32'(s),      32'(m.s));
        check({tag, ".borrow"}, 32'(borrow), 32'(m.borrow));
        check({tag, ".zero"},   32'(zero),   32'(m.zero));
    endtask

    // Drive one cycle of stimulus at the falling edge, push the expected
    // registered result, then pop and compare just after the rising edge.
    task automatic cycle(input string tag, input logic [W-1:0] av,
                         input logic env, input logic rstv);
        reg_exp_t e;
        @(negedge clk);
        a     = av;
        en    = env;
        rst_n = rstv;
        #1;
        check_comb(tag);
        if (!rstv) begin
            held = '{s: '0, borrow: 1'b0, zero: 1'b0};
        end else if (env) begin
            held = model(av);
        end
        sb_q.push_back(held);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".s_q"},      32'(s_q),      32'(e.s));
            check({tag, ".borrow_q"}, 32'(borrow_q), 32'(e.borrow));
            check({tag, ".zero_q"},   32'(zero_q),   32'(e.zero));
        end
    endtask

    initial begin
        vec_t vecs[12];

        vecs[0]  = '{a: 14'h0000, s: 14'h3FFF, borrow: 1'b1, zero: 1'b0};
        vecs[1]  = '{a: 14'h3FFF, s: 14'h3FFE, borrow: 1'b0, zero: 1'b0};
        vecs[2]  = '{a: 14'h1FFF, s: 14'h1FFE, borrow: 1'b0, zero: 1'b0};
        vecs[3]  = '{a: 14'h1000, s: 14'h0FFF, borrow: 1'b0, zero: 1'b0};
        vecs[4]  = '{a: 14'h0800, s: 14'h07FF, borrow: 1'b0, zero: 1'b0};
        vecs[5]  = '{a: 14'h0400, s: 14'h03FF, borrow: 1'b0, zero: 1'b0};
        vecs[6]  = '{a: 14'h0100, s: 14'h00FF, borrow: 1'b0, zero: 1'b0};
        vecs[7]  = '{a: 14'h0040, s: 14'h003F, borrow: 1'b0, zero: 1'b0};
        vecs[8]  = '{a: 14'h0010, s: 14'h000F, borrow: 1'b0, zero: 1'b0};
        vecs[9]  = '{a: 14'h0008, s: 14'h0007, borrow: 1'b0, zero: 1'b0};
        vecs[10] = '{a: 14'h0002, s: 14'h0001, borrow: 1'b0, zero: 1'b0};
        vecs[11] = '{a: 14'h0001, s: 14'h0000, borrow: 1'b0, zero: 1'b1};

        held  = '{s: '0, borrow: 1'b0, zero: 1'b0};
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;

        // Combinational sweep, held in reset to show independence from it.
        for (int i = 0; i < 12; i++) begin
            a = vecs[i].a;
            #10;
            check($sformatf("sweep[%0d].s", i),      32'(s),      32'(vecs[i].s));
            check($sformatf("sweep[%0d].borrow", i), 32'(borrow), 32'(vecs[i].borrow));
            check($sformatf("sweep[%0d].zero", i),   32'(zero),   32'(vecs[i].zero));
        end

        // Reset with en high: registered outputs stay clear, s tracks a.
        cycle("rst0", 14'h0005, 1'b1, 1'b0);
        cycle("rst1", 14'h0005, 1'b1, 1'b0);
        check("rst.s_comb", 32'(s), 32'h0004);

        // Capture the wrap case, then the zero case.
        cycle("cap_wrap", 14'h0000, 1'b1, 1'b1);
        check("cap_wrap.s_q_lit", 32'(s_q), 32'h3FFF);
        cycle("cap_zero", 14'h0001, 1'b1, 1'b1);
        check("cap_zero.zero_q_lit", 32'(zero_q), 32'h1);

        // Hold with en low across three edges while a changes.
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("hold%0d", i), 14'h2A2A, 1'b0, 1'b1);
        end
        check("hold.s_comb", 32'(s), 32'h2A29);
        check("hold.s_q_lit", 32'(s_q), 32'h0000);

        // Mid-stream reset pulse, then reload.
        cycle("mid_load", 14'h1235, 1'b1, 1'b1);
        check("mid_load.s_q_lit", 32'(s_q), 32'h1234);
        cycle("mid_rst", 14'h1235, 1'b1, 1'b0);
        check("mid_rst.s_comb", 32'(s), 32'h1234);
        cycle("mid_reload", 14'h1235, 1'b1, 1'b1);

        // Randomised operands with random enable.
        for (int i = 0; i < 1000; i++) begin
            cycle($sformatf("rnd%0d", i), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end

        if (sb_q.size() != 0) begin
            check("sb_leftover", 32'(sb_q.size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
